multi_clock_divider: RTL and testbench
======================================

# multi_clock_divider

Parametrised multi-channel clock/tick generator that replaces the single-channel fixed-ratio divider. Each channel has a runtime-programmable period and high time. New values are applied glitch-free at the period boundary. Each channel also produces a one-cycle tick strobe. It sits between the board clock and slow consumers (display scan, blink timers, debounce samplers) as their common timing source.

## Interface
- NUM_CH, 4: number of independent channels (1..16)
- DIV_W, 26: width of period/high-time fields
- RESET_DIV, 50000000: period loaded into every channel at reset
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- en  in  NUM_CH  per-channel run enable
- load  in  1  single-cycle load strobe
- load_ch  in  $clog2(NUM_CH)  channel addressed by load
- load_div  in  DIV_W  new period N, in clk cycles
- load_high  in  DIV_W  new high time H, in clk cycles
- load_err  out  1  one-cycle pulse when a load is rejected
- clk_out  out  NUM_CH  divided clock per channel, registered
- tick  out  NUM_CH  one-cycle pulse at the start of each period
- align  in  1  phase-align strobe (present only with PHASE_ALIGN_EN)

## Operation
- Per channel state:
  - cnt: 0..N-1
  - active (N, H)
  - shadow (N, H)
  - pend flag
- Reset:
  - cnt=0
  - active and shadow N=RESET_DIV, H=RESET_DIV/2
  - pend=0
  - clk_out=0, tick=0, load_err=0
- Counting (en=1):
  - cnt increments each cycle.
  - At cnt==N-1, cnt wraps to 0.
- Output decode: clk_out_d = (cnt >= N-H_sat), where H_sat = min(H, N).
  - Each period is low first, then high.
  - H=0 gives constant low; H>=N gives constant high.
- Load rules:
  - A load with load_div<2 or load_ch>=NUM_CH is rejected.
  - On rejection, load_err pulses next cycle and no state changes.
  - An accepted load writes shadow and sets pend.
  - A later load before the boundary overwrites shadow (last write wins).
- Apply rules:
  - If pend and cnt==N-1 with en=1, active<=shadow and pend clears at the wrap.
  - A load in the same cycle as the wrap is applied at that wrap.
  - If en=0 and pend, apply on the next cycle and set cnt=0.
- Disable (en=0):
  - cnt holds.
  - clk_out holds its last value.
  - tick=0.
  - Re-enable resumes from the held cnt.
- Synchronous reset mid-period overrides everything, including a pending load, which is discarded.
- Arithmetic: cnt and comparisons are DIV_W wide unsigned, with no division in hardware. The N-H_sat subtraction is registered when active is updated.

## Timing
- clk_out and tick are registered: one cycle of latency from cnt.
- tick is high in the cycle after cnt==N-1, i.e. coincident with the falling edge of clk_out when 0<H<N.
- Period is exactly N clk cycles and high time is exactly H_sat cycles for every completed period.
- First tick after reset occurs on cycle RESET_DIV (counting the first post-reset cycle as cycle 1).
- load_err is asserted the cycle after the rejected load, for exactly one cycle.
- A new period becomes visible on clk_out starting from the period after the boundary.

## Configuration
- PHASE_ALIGN_EN: when defined, adds the align input.
  - An align pulse forces cnt=0 in all channels in the same cycle and applies any pending shadow values.
  - Outputs then follow from cnt=0 with the normal one-cycle latency.
  - Channels with equal N become phase-locked.
  - align has priority over load apply but not over reset.
- Undefined: the port is absent and channels are fully independent.

## Structure
- Package clkdiv_pkg holds:
  - DIV_W default
  - typedef div_t (logic [DIV_W-1:0])
  - struct div_cfg_t {div_t n; div_t h;}
  - MIN_DIV=2
- Sub-module clkdiv_channel contains one channel:
  - cnt, active/shadow regs, pend flag, decode, output regs.
- The top level does load decode and validation, drives load_err, and instantiates clkdiv_channel in a generate loop.

## Test plan
- Reset then run ch0 with RESET_DIV overridden to 10 -> first tick on cycle 10; clk_out low 5 cycles, high 5; period 10.
- Load ch1 N=7 H=2 mid-period -> old period completes unchanged; then 7-cycle periods, high 2, with tick at each wrap.
- Load N=1 on ch2, and separately load_ch=NUM_CH -> load_err one-cycle pulse for each; ch2 output unchanged.
- ch3 N=4: first load H=0, then load H=9 -> constant low, then constant high after the boundary; tick still every 4 cycles.
- Drop en on ch0 for 13 cycles mid-high phase -> clk_out held high, no tick; resumes with the same remaining count.
- PHASE_ALIGN_EN with ch0/ch1 N=6 offset by 3 -> align pulse -> both ticks coincide thereafter; assert reset mid-period -> all outputs 0 next cycle and pending loads are lost.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the multi-channel clock divider.
package clkdiv_pkg;

  // Default width of period / high-time fields.
  localparam int DEF_DIV_W = 26;

  // Smallest period a channel accepts; N=1 cannot have a low and a high phase.
  localparam int MIN_DIV = 2;

  typedef logic [DEF_DIV_W-1:0] div_t;

  typedef struct packed {
    div_t n;
    div_t h;
  } div_cfg_t;

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/shadow configuration, pending flag,
// threshold decode and registered clk_out / tick outputs.
module clkdiv_channel #(
  parameter int DIV_W     = clkdiv_pkg::DEF_DIV_W,
  parameter int RESET_DIV = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             align,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  input  logic [DIV_W-1:0] load_high,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] RST_N   = DIV_W'(RESET_DIV);
  localparam logic [DIV_W-1:0] RST_H   = DIV_W'(RESET_DIV / 2);
  localparam logic [DIV_W-1:0] RST_THR = RST_N - RST_H;

  typedef struct packed {
    logic [DIV_W-1:0] n;
    logic [DIV_W-1:0] h;
  } cfg_t;

  // Active config keeps N and the precomputed N-H_sat threshold; H itself
  // is not needed once the threshold is known.
  logic [DIV_W-1:0] cnt_reg, cnt_next;
  logic [DIV_W-1:0] act_n_reg;
  logic [DIV_W-1:0] act_thr_reg;
  cfg_t             shadow_reg;
  logic             pend_reg;
  logic             clk_out_reg;
  logic             tick_reg;

  logic             wrap;
  logic             apply;
  cfg_t             new_cfg;
  logic [DIV_W-1:0] new_h_sat;
  logic [DIV_W-1:0] new_thr;

  // Wrap detect, apply decision and next count.
  always_comb begin
    wrap      = (cnt_reg == (act_n_reg - ONE));
    // A load arriving this cycle wins over the stored shadow (last write wins).
    new_cfg   = load ? cfg_t'{n: load_div, h: load_high} : shadow_reg;
    new_h_sat = (new_cfg.h > new_cfg.n) ? new_cfg.n : new_cfg.h;
    new_thr   = new_cfg.n - new_h_sat;
    // Running channels swap config at the wrap; a stopped channel with a
    // pending update takes it immediately; align takes it unconditionally.
    apply     = (load | pend_reg) & (align | (en & wrap) | (~en & pend_reg));

    cnt_next = cnt_reg;
    if (align) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = wrap ? '0 : (cnt_reg + ONE);
    end else if (pend_reg) begin
      cnt_next = '0;
    end
  end

  // Counter and configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg     <= '0;
      act_n_reg   <= RST_N;
      act_thr_reg <= RST_THR;
      shadow_reg  <= cfg_t'{n: RST_N, h: RST_H};
      pend_reg    <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      if (load) begin
        shadow_reg <= new_cfg;
      end
      if (apply) begin
        act_n_reg   <= new_cfg.n;
        act_thr_reg <= new_thr;
        pend_reg    <= 1'b0;
      end else if (load) begin
        pend_reg <= 1'b1;
      end
    end
  end

  // Registered outputs; clk_out freezes and tick stays low while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_out_reg <= 1'b0;
      tick_reg    <= 1'b0;
    end else if (en) begin
      clk_out_reg <= (cnt_reg >= act_thr_reg);
      tick_reg    <= wrap;
    end else begin
      tick_reg <= 1'b0;
    end
  end

  assign clk_out = clk_out_reg;
  assign tick    = tick_reg;

endmodule

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock/tick generator. The top level validates
// loads, reports rejections on load_err and fans out to per-channel dividers.
// Optional macro PHASE_ALIGN_EN adds the align input that restarts every
// channel at cnt=0 in the same cycle.
module multi_clock_divider #(
  parameter int NUM_CH    = 4,
  parameter int DIV_W     = clkdiv_pkg::DEF_DIV_W,
  parameter int RESET_DIV = 50000000,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              load,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [DIV_W-1:0]  load_div,
  input  logic [DIV_W-1:0]  load_high,
`ifdef PHASE_ALIGN_EN
  input  logic              align,
`endif
  output logic              load_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  import clkdiv_pkg::*;

  logic load_bad;
  logic load_ok;
  logic load_err_reg;
  logic align_int;

`ifdef PHASE_ALIGN_EN
  assign align_int = align;
`else
  assign align_int = 1'b0;
`endif

  // A load is rejected for a too-short period or a nonexistent channel.
  always_comb begin
    load_bad = (load_div < DIV_W'(MIN_DIV)) |
               ({1'b0, load_ch} >= (CH_W + 1)'(NUM_CH));
    load_ok  = load & ~load_bad;
  end

  // One-cycle rejection pulse, the cycle after the offending load.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_err_reg <= 1'b0;
    end else begin
      load_err_reg <= load & load_bad;
    end
  end

  assign load_err = load_err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      clkdiv_channel #(
        .DIV_W     (DIV_W),
        .RESET_DIV (RESET_DIV)
      ) u_ch (
        .clk       (clk),
        .reset     (reset),
        .en        (en[gi]),
        .align     (align_int),
        .load      (load_ok & (load_ch == CH_W'(gi))),
        .load_div  (load_div),
        .load_high (load_high),
        .clk_out   (clk_out[gi]),
        .tick      (tick[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_clock_divider.sv
// Scoreboard bench for multi_clock_divider: the stimulus loop pushes the
// expected outputs for each cycle, and a monitor compares them just after
// the clock edge. Cycle 0 is the reset-state cycle; cycle c is the state
// after the c-th counting edge. Inputs driven in cycle c act at edge c+1.
module tb_multi_clock_divider;

  localparam int NUM_CH    = 5;
  localparam int DIV_W     = 8;
  localparam int RESET_DIV = 10;
  localparam int CH_W      = 3;
  localparam int LAST      = 150;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NUM_CH-1:0] en = '1;
  logic              load = 1'b0;
  logic [CH_W-1:0]   load_ch = '0;
  logic [DIV_W-1:0]  load_div = '0;
  logic [DIV_W-1:0]  load_high = '0;
  logic              load_err;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
`ifdef PHASE_ALIGN_EN
  logic              align = 1'b0;
`endif

  multi_clock_divider #(
    .NUM_CH    (NUM_CH),
    .DIV_W     (DIV_W),
    .RESET_DIV (RESET_DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .load      (load),
    .load_ch   (load_ch),
    .load_div  (load_div),
    .load_high (load_high),
`ifdef PHASE_ALIGN_EN
    .align     (align),
`endif
    .load_err  (load_err),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  int cyc = -2;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    int   kind;   // 0 clk_out, 1 tick, 2 load_err
    int   ch;
    logic val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Expected {clk_out, tick} for a channel running period n, high h, whose
  // counter was 0 in cycle 'anchor' (outputs lag the counter by one cycle).
  function automatic logic [1:0] per(int c, int anchor, int n, int h);
    int k;
    int hs;
    k  = (c - 1 - anchor) % n;
    hs = (h > n) ? n : h;
    return {logic'(k >= n - hs), logic'(k == n - 1)};
  endfunction

  task automatic push(int c, int kind, int ch, logic v);
    exp_t e;
    e.cyc  = c;
    e.kind = kind;
    e.ch   = ch;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic push_ch(int c, int ch, logic [1:0] v);
    push(c, 0, ch, v[1]);
    push(c, 1, ch, v[0]);
  endtask

  // Hand-planned expectations per cycle.
  task automatic push_cycle(int c);
    if (c == 0 || c == 88) begin
      for (int ch = 0; ch < NUM_CH; ch++) push_ch(c, ch, 2'b00);
      push(c, 2, 0, 1'b0);
    end
    // ch0: reset period 10/5, en dropped for edges 58..70 with cnt held at 7
    if (c >= 1 && c <= 57)       push_ch(c, 0, per(c, 0, 10, 5));
    else if (c >= 58 && c <= 70) push_ch(c, 0, 2'b10);
    else if (c >= 71 && c <= 87) push_ch(c, 0, per(c, 13, 10, 5));
    // ch1: load 7/2 at edge 14, old period ends at edge 20
    if (c >= 14 && c <= 20)      push_ch(c, 1, per(c, 0, 10, 5));
    else if (c >= 21 && c <= 40) push_ch(c, 1, per(c, 20, 7, 2));
    // ch2: unaffected by rejected loads; pending load lost at reset
    if (c >= 22 && c <= 50)      push_ch(c, 2, per(c, 0, 10, 5));
    else if (c >= 89 && c <= 110) push_ch(c, 2, per(c, 88, 10, 5));
    // ch3: 4/0 applied at edge 40, 4/9 applied at edge 48
    if (c >= 32 && c <= 40)      push_ch(c, 3, per(c, 0, 10, 5));
    else if (c >= 41 && c <= 48) push_ch(c, 3, per(c, 40, 4, 0));
    else if (c >= 49 && c <= 60) push_ch(c, 3, per(c, 48, 4, 9));
    // load_err pulses only after the two rejected loads
    if (c >= 1 && c <= 110 && c != 88) push(c, 2, 0, logic'(c == 23 || c == 26));
`ifdef PHASE_ALIGN_EN
    if (c >= 132 && c <= LAST) begin
      push_ch(c, 0, per(c, 131, 6, 3));
      push_ch(c, 1, per(c, 131, 6, 3));
    end
`endif
  endtask

  task automatic do_load(int ch, int n, int h);
    load      = 1'b1;
    load_ch   = CH_W'(ch);
    load_div  = DIV_W'(n);
    load_high = DIV_W'(h);
  endtask

  task automatic drive(int c);
    load = 1'b0;
`ifdef PHASE_ALIGN_EN
    align = 1'b0;
`endif
    case (c)
      0:   reset = 1'b0;
      13:  do_load(1, 7, 2);
      22:  do_load(2, 1, 5);
      25:  do_load(5, 9, 3);
      31:  do_load(3, 4, 0);
      45:  do_load(3, 4, 9);
      57:  en[0] = 1'b0;
      70:  en[0] = 1'b1;
      86:  do_load(2, 3, 1);
      87:  reset = 1'b1;
      88:  reset = 1'b0;
      110: do_load(0, 6, 3);
      111: do_load(1, 6, 3);
      120: en[1] = 1'b0;
      123: en[1] = 1'b1;
`ifdef PHASE_ALIGN_EN
      130: align = 1'b1;
`endif
      default: ;
    endcase
  endtask

  // Monitor: compare every expectation due in the current cycle.
  always @(posedge clk) begin
    logic  act;
    string nm;
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          0:       begin act = clk_out[sb[i].ch]; nm = "clk_out"; end
          1:       begin act = tick[sb[i].ch];    nm = "tick";    end
          default: begin act = load_err;          nm = "load_err"; end
        endcase
        n_cmp++;
        if (act !== sb[i].val) begin
          n_bad++;
          $display("FAIL cyc=%0d %s ch%0d got=%b want=%b", cyc, nm, sb[i].ch, act, sb[i].val);
        end else begin
          $display("ok   cyc=%0d %s ch%0d = %b", cyc, nm, sb[i].ch, act);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    @(negedge clk);
    reset = 1'b1;
    push_cycle(0);
    for (int c = 0; c <= LAST; c++) begin
      @(negedge clk);
      drive(c);
      push_cycle(c + 1);
    end
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
